espirometro_uart_tx: RTL and testbench

- Transmit side of the spirometer-to-Android link.
- Takes the patient weight captured at session start and the final flow measurement, and frames them into a fixed 5-byte packet.
- Serialises the packet over an 8N1 UART line to the Bluetooth/serial module feeding the Android app.
- Sits after the weight latch and the flow accumulator; the main state machine triggers it when a result is ready.

---
 rtl/espirometro_pkg.sv | 57 +++++
 rtl/espirometro_baud_gen.sv | 44 ++++
 rtl/espirometro_uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_espirometro_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/espirometro_pkg.sv
// ---------------------------------------------------------------------------
// espirometro_pkg
// Shared definitions for the spirometer-to-Android UART transmit path.
//   - tx_state_e   : transmitter FSM state encoding
//   - PKT_BYTES    : number of bytes in one result packet
//   - ST_RESULT    : main FSM state value in which a send request is honoured
//   - pkt_checksum : 8-bit wrapping sum of the first four packet bytes
//   - pkt_byte     : selects packet byte N from the snapshot registers
// The PARITY state is always present in the encoding; it is only entered when
// the transmitter is built with ESPIRO_TX_PARITY_EN defined.
// ---------------------------------------------------------------------------
package espirometro_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } tx_state_e;

    localparam int         PKT_BYTES = 5;
    localparam logic [1:0] ST_RESULT = 2'd2;

    // Carries out of bit 7 are discarded, so the sum simply wraps at 256.
    function automatic logic [7:0] pkt_checksum(
        input logic [7:0]  header,
        input logic [7:0]  peso,
        input logic [15:0] flujo
    );
        logic [7:0] sum;
        sum = header + peso + flujo[15:8] + flujo[7:0];
        return sum;
    endfunction

    // Packet order: header, weight, flow high byte, flow low byte, checksum.
    function automatic logic [7:0] pkt_byte(
        input logic [2:0]  idx,
        input logic [7:0]  header,
        input logic [7:0]  peso,
        input logic [15:0] flujo,
        input logic [7:0]  chk
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = header;
            3'd1:    b = peso;
            3'd2:    b = flujo[15:8];
            3'd3:    b = flujo[7:0];
            3'd4:    b = chk;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/espirometro_baud_gen.sv
// ---------------------------------------------------------------------------
// espirometro_baud_gen
// Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 while
// enabled and flags the last cycle of each bit period with o_bitTick.
// Ports:
//   Clk       - system clock, rising edge
//   Rst       - asynchronous active-high reset
//   i_enable  - count while high; counter held at 0 while low
//   i_clear   - restart the bit period (counter back to 0 next cycle)
//   o_bitTick - high during the final cycle of the current bit period
// ---------------------------------------------------------------------------
module espirometro_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_bitTick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // Free-running bit timer; the FSM restarts it whenever a new bit begins
    // so every bit lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count <= '0;
        end else if (i_clear || !i_enable) begin
            r_count <= '0;
        end else if (r_count == LAST_COUNT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Tick is not gated by i_clear: the FSM derives its clear from this tick.
    assign o_bitTick = i_enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/espirometro_uart_tx.sv
// ---------------------------------------------------------------------------
// espirometro_uart_tx
// Frames the latched patient weight and the final flow value into a 5-byte
// packet (A5, peso, flujo[15:8], flujo[7:0], checksum) and shifts it out on
// an 8N1 UART line, LSB first, with no idle gap between bytes.
// Optional build macro: ESPIRO_TX_PARITY_EN adds an even parity bit between
// the data bits and the stop bit (11 bits per byte).
// Ports:
//   Clk            - system clock, rising edge
//   Rst            - asynchronous active-high reset
//   iStart         - single-cycle send request
//   ivStateMachine - main FSM state; requests honoured only in ST_RESULT
//   ivPeso         - latched patient weight
//   ivFlujo        - flow measurement, unsigned
//   oTx            - UART serial line, idles high
//   oBusy          - high while a packet is in flight
//   oDone          - one-cycle pulse when the packet has completed
// ---------------------------------------------------------------------------
module espirometro_uart_tx
    import espirometro_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        iStart,
    input  logic [1:0]  ivStateMachine,
    input  logic [7:0]  ivPeso,
    input  logic [15:0] ivFlujo,
    output logic        oTx,
    output logic        oBusy,
    output logic        oDone
);

    tx_state_e   r_state;
    logic [7:0]  r_peso;
    logic [15:0] r_flujo;
    logic [7:0]  r_checksum;
    logic [2:0]  r_byteIdx;
    logic [2:0]  r_bitIdx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;
`ifdef ESPIRO_TX_PARITY_EN
    logic        r_parity;
`endif

    logic        w_accept;
    logic        w_bitTick;
    logic        w_baudEn;
    logic        w_baudClr;
    logic        w_lastByte;
    logic [7:0]  w_nextByte;

    assign w_accept   = (r_state == S_IDLE) && iStart && (ivStateMachine == ST_RESULT);
    assign w_lastByte = (r_byteIdx == 3'(PKT_BYTES - 1));
    assign w_nextByte = pkt_byte(r_byteIdx + 3'd1, HEADER_BYTE, r_peso, r_flujo, r_checksum);

    // Every tick either enters a new state or starts the next data bit, and
    // accept enters START, so clearing on these restarts each bit period.
    assign w_baudEn  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_baudClr = w_accept || w_bitTick;

    espirometro_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baudGen (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_enable  (w_baudEn),
        .i_clear   (w_baudClr),
        .o_bitTick (w_bitTick)
    );

    // Transmit FSM. oTx/oBusy/oDone are assigned the value for the state
    // being entered, so the line changes on the same edge as the state and
    // never glitches. Data bits go out of r_shift LSB first.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_peso     <= '0;
            r_flujo    <= '0;
            r_checksum <= '0;
            r_byteIdx  <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef ESPIRO_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_peso     <= ivPeso;
                        r_flujo    <= ivFlujo;
                        r_checksum <= pkt_checksum(HEADER_BYTE, ivPeso, ivFlujo);
                        r_byteIdx  <= '0;
                        r_shift    <= HEADER_BYTE;
`ifdef ESPIRO_TX_PARITY_EN
                        r_parity   <= ^HEADER_BYTE;
`endif
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_bitTick) begin
                        r_bitIdx <= '0;
                        r_tx     <= r_shift[0];
                        r_state  <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_bitTick) begin
                        if (r_bitIdx == 3'd7) begin
`ifdef ESPIRO_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_shift  <= r_shift >> 1;
                            r_tx     <= r_shift[1];
                        end
                    end
                end

`ifdef ESPIRO_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bitTick) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    if (w_bitTick) begin
                        if (w_lastByte) begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Back-to-back bytes: next start bit follows the stop bit.
                            r_byteIdx <= r_byteIdx + 3'd1;
                            r_shift   <= w_nextByte;
`ifdef ESPIRO_TX_PARITY_EN
                            r_parity  <= ^w_nextByte;
`endif
                            r_tx      <= 1'b0;
                            r_state   <= S_START;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oTx   = r_tx;
    assign oBusy = r_busy;
    assign oDone = r_done;

endmodule

// File: tb/tb_espirometro_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_espirometro_uart_tx
// Self-checking bench for espirometro_uart_tx with CLKS_PER_BIT=4. Expected
// packet bytes go into a queue when a send is requested; a line decoder pops
// and compares them as bytes appear on oTx. Frame timing, busy/done
// behaviour, ignored requests and asynchronous reset are checked directly.
// ---------------------------------------------------------------------------
module tb_espirometro_uart_tx;

    localparam int CPB = 4;
`ifdef ESPIRO_TX_PARITY_EN
    localparam int BITS_PER_BYTE = 11;
`else
    localparam int BITS_PER_BYTE = 10;
`endif
    localparam int FRAME = 5 * BITS_PER_BYTE * CPB;

    logic        Clk;
    logic        Rst;
    logic        iStart;
    logic [1:0]  ivStateMachine;
    logic [7:0]  ivPeso;
    logic [15:0] ivFlujo;
    logic        oTx;
    logic        oBusy;
    logic        oDone;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] expQ[$];

    typedef struct {
        logic [1:0]  sm;
        logic [7:0]  peso;
        logic [15:0] flujo;
        logic        accept;
        logic [7:0]  chk;
    } vec_t;

    vec_t vecs[7];

    espirometro_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .HEADER_BYTE  (8'hA5)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .iStart         (iStart),
        .ivStateMachine (ivStateMachine),
        .ivPeso         (ivPeso),
        .ivFlujo        (ivFlujo),
        .oTx            (oTx),
        .oBusy          (oBusy),
        .oDone          (oDone)
    );

    // 10-unit clock; the bench drives and samples on the falling edge.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushPacket(input logic [7:0] peso, input logic [15:0] flujo, input logic [7:0] chk);
        expQ.push_back(8'hA5);
        expQ.push_back(peso);
        expQ.push_back(flujo[15:8]);
        expQ.push_back(flujo[7:0]);
        expQ.push_back(chk);
    endtask

    // Ends on the first sample after the edge that saw iStart.
    task automatic applyStimulus(input logic [1:0] sm, input logic [7:0] peso, input logic [15:0] flujo);
        @(negedge Clk);
        ivStateMachine = sm;
        ivPeso         = peso;
        ivFlujo        = flujo;
        iStart         = 1'b1;
        @(negedge Clk);
        iStart = 1'b0;
    endtask

    // Starts on sample 1 after accept, returns on the sample where oDone is
    // seen (or the budget runs out). retrigAt!=0 fires a second request then.
    task automatic measureFrame(input string tag, input int retrigAt);
        int   n       = 1;
        int   busyCnt = 0;
        logic low4    = 1'b1;
        while (oDone !== 1'b1 && n < FRAME + 50) begin
            if (n <= CPB && oTx !== 1'b0) low4 = 1'b0;
            if (oBusy === 1'b1) busyCnt++;
            if (retrigAt != 0 && n == retrigAt) begin
                ivPeso  = 8'hFF;
                ivFlujo = 16'h0000;
                iStart  = 1'b1;
            end else begin
                iStart = 1'b0;
            end
            @(negedge Clk);
            n++;
        end
        iStart = 1'b0;
        checkOutput({tag, " start bit low"}, 32'(low4), 32'd1);
        checkOutput({tag, " done latency"}, n, FRAME + 1);
        checkOutput({tag, " busy cycles"}, busyCnt, FRAME);
        checkOutput({tag, " busy low at done"}, 32'(oBusy), 32'd0);
    endtask

    task automatic postDone(input string tag);
        @(negedge Clk);
        checkOutput({tag, " done one cycle"}, 32'(oDone), 32'd0);
        checkOutput({tag, " all bytes seen"}, expQ.size(), 32'd0);
    endtask

    task automatic sendAndCheck(input logic [7:0] peso, input logic [15:0] flujo, input logic [7:0] chk,
                                input string tag, input int retrigAt);
        pushPacket(peso, flujo, chk);
        applyStimulus(2'd2, peso, flujo);
        measureFrame(tag, retrigAt);
        postDone(tag);
    endtask

    // Monitor helpers: wait k samples, abandoning the byte if reset is seen.
    task automatic waitSamples(input int k, output logic abort);
        abort = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(negedge Clk);
            if (Rst === 1'b1) begin
                abort = 1'b1;
                return;
            end
        end
    endtask

    task automatic decodeByte();
        logic [7:0] b;
        logic [7:0] exp;
        logic       abort;
        logic       startMid;
        logic       stopBit;
        logic       parBit;
        parBit = 1'b0;
        waitSamples(2, abort);
        if (abort) return;
        startMid = oTx;
        for (int i = 0; i < 8; i++) begin
            waitSamples(CPB, abort);
            if (abort) return;
            b[i] = oTx;
        end
`ifdef ESPIRO_TX_PARITY_EN
        waitSamples(CPB, abort);
        if (abort) return;
        parBit = oTx;
`endif
        waitSamples(CPB, abort);
        if (abort) return;
        stopBit = oTx;
        checkOutput("start bit mid", 32'(startMid), 32'd0);
        checkOutput("stop bit", 32'(stopBit), 32'd1);
        checkOutput("byte expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
            exp = expQ.pop_front();
            checkOutput("line byte", 32'(b), 32'(exp));
`ifdef ESPIRO_TX_PARITY_EN
            checkOutput("parity bit", 32'(parBit), 32'(^exp));
`endif
        end
        waitSamples(1, abort);
    endtask

    initial begin : lineMonitor
        forever begin
            @(negedge Clk);
            if (Rst === 1'b0 && oTx === 1'b0) decodeByte();
        end
    end

    initial begin : mainTest
        int bad;
        int doneCnt;
        int n;

        vecs[0] = '{sm: 2'd2, peso: 8'h46, flujo: 16'h1234, accept: 1'b1, chk: 8'h31};
        vecs[1] = '{sm: 2'd1, peso: 8'h11, flujo: 16'h2222, accept: 1'b0, chk: 8'h00};
        vecs[2] = '{sm: 2'd2, peso: 8'hFF, flujo: 16'hFFFF, accept: 1'b1, chk: 8'hA2};
        vecs[3] = '{sm: 2'd0, peso: 8'h33, flujo: 16'h4444, accept: 1'b0, chk: 8'h00};
        vecs[4] = '{sm: 2'd3, peso: 8'h55, flujo: 16'h6666, accept: 1'b0, chk: 8'h00};
        vecs[5] = '{sm: 2'd2, peso: 8'h00, flujo: 16'h0000, accept: 1'b1, chk: 8'hA5};
        vecs[6] = '{sm: 2'd2, peso: 8'h5A, flujo: 16'h80C3, accept: 1'b1, chk: 8'h42};

        Rst            = 1'b1;
        iStart         = 1'b0;
        ivStateMachine = 2'd0;
        ivPeso         = 8'h00;
        ivFlujo        = 16'h0000;

        // Reset values, then a quiet line with no requests.
        repeat (3) @(negedge Clk);
        checkOutput("reset oTx", 32'(oTx), 32'd1);
        checkOutput("reset oBusy", 32'(oBusy), 32'd0);
        checkOutput("reset oDone", 32'(oDone), 32'd0);
        Rst = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge Clk);
            if (oTx !== 1'b1 || oBusy !== 1'b0 || oDone !== 1'b0) bad++;
        end
        checkOutput("idle after reset", bad, 0);

        // Table of accepted and rejected requests.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].accept) begin
                sendAndCheck(vecs[v].peso, vecs[v].flujo, vecs[v].chk, $sformatf("vec%0d", v), 0);
            end else begin
                applyStimulus(vecs[v].sm, vecs[v].peso, vecs[v].flujo);
                bad = 0;
                repeat (20) begin
                    if (oTx !== 1'b1 || oBusy !== 1'b0) bad++;
                    @(negedge Clk);
                end
                checkOutput($sformatf("vec%0d request ignored", v), bad, 0);
            end
        end

        // Request while busy, with new inputs, must not disturb the packet.
        ivStateMachine = 2'd2;
        sendAndCheck(8'h46, 16'h1234, 8'h31, "busy retrigger", 50);
        doneCnt = 0;
        repeat (FRAME + 50) begin
            if (oDone === 1'b1) doneCnt++;
            @(negedge Clk);
        end
        checkOutput("no second done", doneCnt, 0);

        // Request during the DONE cycle is ignored; the next cycle is accepted.
        pushPacket(8'h46, 16'h1234, 8'h31);
        applyStimulus(2'd2, 8'h46, 16'h1234);
        measureFrame("rt first", 0);
        pushPacket(8'h5A, 16'h80C3, 8'h42);
        ivPeso  = 8'h5A;
        ivFlujo = 16'h80C3;
        iStart  = 1'b1;
        @(negedge Clk);
        checkOutput("start in DONE ignored tx", 32'(oTx), 32'd1);
        checkOutput("start in DONE ignored busy", 32'(oBusy), 32'd0);
        @(negedge Clk);
        iStart = 1'b0;
        measureFrame("rt second", 0);
        postDone("rt second");

        // Asynchronous reset in the middle of B2.
        pushPacket(8'h46, 16'h1234, 8'h31);
        applyStimulus(2'd2, 8'h46, 16'h1234);
        n = 1;
        while (n < 90) begin
            @(negedge Clk);
            n++;
        end
        #2 Rst = 1'b1;
        #1;
        checkOutput("async reset oTx", 32'(oTx), 32'd1);
        checkOutput("async reset oBusy", 32'(oBusy), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        expQ.delete();
        Rst = 1'b0;
        doneCnt = 0;
        bad     = 0;
        repeat (FRAME) begin
            @(negedge Clk);
            if (oDone === 1'b1) doneCnt++;
            if (oTx !== 1'b1) bad++;
        end
        checkOutput("no done after reset", doneCnt, 0);
        checkOutput("line idle after reset", bad, 0);
        sendAndCheck(8'h46, 16'h1234, 8'h31, "after reset", 0);

        repeat (10) @(negedge Clk);
        checkOutput("final queue empty", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
